// File: rtl/dcache_mshr_ctrl_pkg.sv
// Shared encodings and command-FIFO entry layout for the data-cache miss controller.
package dcache_mshr_ctrl_pkg;

   localparam int unsigned ADDR_W       = 64;
   localparam int unsigned DATA_W       = 64;
   localparam int unsigned MTAG_W       = 4;
   localparam int unsigned LINE_W       = 29;
   localparam int unsigned DEF_IDX_BITS = 7;
   localparam int unsigned DEF_TAG_BITS = 22;
   localparam int unsigned ENT_PR_W     = 7;
   localparam int unsigned ENT_AR_W     = 5;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_e;

   typedef struct packed {
      bus_cmd_e                cmd;
      logic [ADDR_W-1:0]       addr;
      logic [DATA_W-1:0]       data;
      logic [ENT_PR_W-1:0]     pr;
      logic [ENT_AR_W-1:0]     ar;
   } cmd_entry_t;

   // Cache-line address (addr[31:3]) used for store/load hazard matching.
   function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
      return a[31:3];
   endfunction

endpackage

// File: rtl/dcache_mshr_ctrl_if.sv
// Tagged data-memory bus between the miss controller (master) and memory (slave).
interface dcache_mshr_ctrl_if;

   logic [1:0]  proc2Dmem_command;
   logic [63:0] proc2Dmem_addr;
   logic [63:0] proc2Dmem_data;
   logic [3:0]  Dmem2proc_response;
   logic [63:0] Dmem2proc_data;
   logic [3:0]  Dmem2proc_tag;

   modport master (
      output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
   );

   modport slave (
      input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag
   );

endinterface

// File: rtl/dcache_cmd_fifo.sv
// In-order command FIFO with occupancy count and a per-entry pending-store line match vector.
module dcache_cmd_fifo
   import dcache_mshr_ctrl_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_push,
   input  cmd_entry_t        i_push_entry,
   input  logic              i_pop,
   input  logic [LINE_W-1:0] i_match_line,
   output cmd_entry_t        o_head,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_full,
   output logic              o_empty,
   output logic [DEPTH-1:0]  o_st_match
);

   cmd_entry_t       r_mem [DEPTH];
   logic [DEPTH-1:0] r_vld;
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_head];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_vld   <= '0;
      end else begin
         if (w_push) begin
            r_vld[r_tail] <= 1'b1;
            r_tail        <= r_tail + PTR_W'(1);
         end
         if (w_pop) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_tail] <= i_push_entry;
   end

   // Flags every live store whose line equals the lookup line (blocks stale hits).
   always_comb begin
      o_st_match = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         o_st_match[i] = r_vld[i] && (r_mem[i].cmd == BUS_STORE) &&
                         (line_of(r_mem[i].addr) == i_match_line);
      end
   end

endmodule

// File: rtl/dcache_mshr_ctrl.sv
// Non-blocking write-through data-cache miss controller with tagged fill table and halt drain.
// Optional saturating performance counters when DCACHE_PERF_CNT_EN is defined.
module dcache_mshr_ctrl
   import dcache_mshr_ctrl_pkg::*;
#(
   parameter  int unsigned Q_DEPTH  = 16,
   parameter  int unsigned MEM_TAGS = 15,
   parameter  int unsigned IDX_BITS = DEF_IDX_BITS,
   parameter  int unsigned TAG_BITS = DEF_TAG_BITS,
   parameter  int unsigned PR_BITS  = 7,
   parameter  int unsigned AR_BITS  = 5,
   localparam int unsigned CNT_W    = $clog2(Q_DEPTH) + 1,
   localparam int unsigned NT       = 1 << MTAG_W
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 lsq_rd_mem,
   input  logic [63:0]          lsq_addr,
   input  logic [PR_BITS-1:0]   lsq_pr,
   input  logic [AR_BITS-1:0]   lsq_ar,
   output logic                 lsq_load_ack,
   input  logic                 rob_wr_mem,
   input  logic [63:0]          rob_st_addr,
   input  logic [63:0]          rob_st_data,
   output logic                 req_stall,
   output logic [IDX_BITS-1:0]  dcache_rd_idx,
   output logic [TAG_BITS-1:0]  dcache_rd_tag,
   input  logic                 cachemem_valid,
   input  logic [63:0]          cachemem_data,
   dcache_mshr_ctrl_if.master   mem,
   output logic                 dcache_wr_en0,
   output logic [IDX_BITS-1:0]  dcache_wr_idx0,
   output logic [TAG_BITS-1:0]  dcache_wr_tag0,
   output logic [63:0]          dcache_wr_data0,
   output logic                 dcache_wr_en1,
   output logic [IDX_BITS-1:0]  dcache_wr_idx1,
   output logic [TAG_BITS-1:0]  dcache_wr_tag1,
   output logic [63:0]          dcache_wr_data1,
   output logic                 cdb_load_en,
   output logic [PR_BITS-1:0]   cdb_pr,
   output logic [AR_BITS-1:0]   cdb_ar,
   output logic [63:0]          cdb_data,
   input  logic                 rob_halt,
   output logic                 halt_done
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]          perf_hits,
   output logic [31:0]          perf_misses,
   output logic [31:0]          perf_stores,
   output logic [31:0]          perf_cdb_conflicts
`endif
);

   function automatic logic tag_usable(input logic [MTAG_W-1:0] t);
      return (t != '0) && (32'(t) <= MEM_TAGS);
   endfunction

   // Outstanding-load table, indexed by memory tag; entry 0 never allocates.
   logic [NT-1:0]       r_occ;
   logic [NT-1:0]       r_nowrite;
   logic [IDX_BITS-1:0] r_t_idx [NT];
   logic [TAG_BITS-1:0] r_t_tag [NT];
   logic [PR_BITS-1:0]  r_t_pr  [NT];
   logic [AR_BITS-1:0]  r_t_ar  [NT];
   logic                r_halted;

   cmd_entry_t          w_head;
   cmd_entry_t          w_head_g;
   cmd_entry_t          w_push_entry;
   logic [CNT_W-1:0]    w_count;
   logic                w_full;
   logic                w_empty;
   logic [Q_DEPTH-1:0]  w_st_match;
   logic [MTAG_W-1:0]   w_resp;
   logic [MTAG_W-1:0]   w_rtag;
   logic                w_fill;
   logic                w_st_haz;
   logic                w_hit_ok;
   logic                w_hit;
   logic                w_conflict;
   logic                w_st_acc;
   logic                w_ld_miss;
   logic                w_push;
   logic                w_pop;
   logic                w_pop_ld;
   logic                w_pop_st;
   logic [IDX_BITS-1:0] w_st_idx;
   logic [TAG_BITS-1:0] w_st_tag;

   dcache_cmd_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_match_line (line_of(lsq_addr)),
      .o_head       (w_head),
      .o_count      (w_count),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_st_match   (w_st_match)
   );

   assign dcache_rd_idx = lsq_addr[IDX_BITS+2:3];
   assign dcache_rd_tag = lsq_addr[IDX_BITS+3 +: TAG_BITS];

   assign w_resp   = mem.Dmem2proc_response;
   assign w_rtag   = mem.Dmem2proc_tag;
   assign w_head_g = w_empty ? '0 : w_head;
   assign w_st_idx = w_head_g.addr[IDX_BITS+2:3];
   assign w_st_tag = w_head_g.addr[IDX_BITS+3 +: TAG_BITS];

   // Request acceptance: stores beat load misses; a returning fill owns the CDB.
   always_comb begin
      w_fill       = tag_usable(w_rtag) && r_occ[w_rtag];
      w_st_haz     = |w_st_match;
      w_hit_ok     = lsq_rd_mem & cachemem_valid & ~w_st_haz & ~r_halted;
      w_hit        = w_hit_ok & ~w_fill;
      w_conflict   = w_hit_ok & w_fill;
      req_stall    = w_full | r_halted;
      w_st_acc     = rob_wr_mem & ~req_stall;
      w_ld_miss    = lsq_rd_mem & ~(cachemem_valid & ~w_st_haz) & ~w_full & ~w_st_acc & ~r_halted;
      lsq_load_ack = w_hit | w_ld_miss;
      w_push       = w_st_acc | w_ld_miss;
      w_push_entry = '0;
      if (w_st_acc) begin
         w_push_entry.cmd  = BUS_STORE;
         w_push_entry.addr = rob_st_addr;
         w_push_entry.data = rob_st_data;
      end else begin
         w_push_entry.cmd  = BUS_LOAD;
         w_push_entry.addr = lsq_addr;
         w_push_entry.pr   = ENT_PR_W'(lsq_pr);
         w_push_entry.ar   = ENT_AR_W'(lsq_ar);
      end
      w_pop    = ~w_empty & (w_resp != '0);
      w_pop_ld = w_pop & (w_head_g.cmd == BUS_LOAD) & tag_usable(w_resp);
      w_pop_st = w_pop & (w_head_g.cmd == BUS_STORE);
   end

   assign mem.proc2Dmem_command = w_head_g.cmd;
   assign mem.proc2Dmem_addr    = w_head_g.addr;
   assign mem.proc2Dmem_data    = w_head_g.data;

   assign dcache_wr_en1   = w_pop_st;
   assign dcache_wr_idx1  = w_st_idx;
   assign dcache_wr_tag1  = w_st_tag;
   assign dcache_wr_data1 = w_head_g.data;

   // A store writing the same set this cycle overrides the fill on port 0.
   assign dcache_wr_en0   = w_fill & ~r_nowrite[w_rtag] & ~(w_pop_st & (w_st_idx == r_t_idx[w_rtag]));
   assign dcache_wr_idx0  = w_fill ? r_t_idx[w_rtag] : '0;
   assign dcache_wr_tag0  = w_fill ? r_t_tag[w_rtag] : '0;
   assign dcache_wr_data0 = w_fill ? mem.Dmem2proc_data : '0;

   assign cdb_load_en = w_fill | w_hit;
   assign cdb_pr      = w_fill ? r_t_pr[w_rtag] : (w_hit ? lsq_pr : '0);
   assign cdb_ar      = w_fill ? r_t_ar[w_rtag] : (w_hit ? lsq_ar : '0);
   assign cdb_data    = w_fill ? mem.Dmem2proc_data : (w_hit ? cachemem_data : '0);

   assign halt_done = r_halted & (w_count == '0) & ~|r_occ;

   // Free on fill before allocating so a tag may recycle in one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_occ     <= '0;
         r_nowrite <= '0;
         r_halted  <= 1'b0;
      end else begin
         if (rob_halt) r_halted <= 1'b1;
         if (w_fill) r_occ[w_rtag] <= 1'b0;
         if (w_pop_st) begin
            for (int i = 0; i < int'(NT); i++) begin
               if (r_occ[i] && (r_t_idx[i] == w_st_idx) && (r_t_tag[i] == w_st_tag))
                  r_nowrite[i] <= 1'b1;
            end
         end
         if (w_pop_ld) begin
            assert (!r_occ[w_resp] || (w_fill && (w_rtag == w_resp)))
               else $error("memory tag %0d allocated while still outstanding", w_resp);
            r_occ[w_resp]     <= 1'b1;
            r_nowrite[w_resp] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_pop_ld) begin
         r_t_idx[w_resp] <= w_st_idx;
         r_t_tag[w_resp] <= w_st_tag;
         r_t_pr[w_resp]  <= PR_BITS'(w_head_g.pr);
         r_t_ar[w_resp]  <= AR_BITS'(w_head_g.ar);
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_hits          <= '0;
         perf_misses        <= '0;
         perf_stores        <= '0;
         perf_cdb_conflicts <= '0;
      end else begin
         if (w_hit && (perf_hits != '1))               perf_hits          <= perf_hits + 32'd1;
         if (w_ld_miss && (perf_misses != '1))         perf_misses        <= perf_misses + 32'd1;
         if (w_st_acc && (perf_stores != '1))          perf_stores        <= perf_stores + 32'd1;
         if (w_conflict && (perf_cdb_conflicts != '1)) perf_cdb_conflicts <= perf_cdb_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_mshr_ctrl.sv
// Directed bench for dcache_mshr_ctrl: hits, misses, store hazards, full FIFO, CDB collision, halt drain.
module tb_dcache_mshr_ctrl;

   logic        clock;
   logic        reset;
   logic        lsq_rd_mem;
   logic [63:0] lsq_addr;
   logic [6:0]  lsq_pr;
   logic [4:0]  lsq_ar;
   logic        lsq_load_ack;
   logic        rob_wr_mem;
   logic [63:0] rob_st_addr;
   logic [63:0] rob_st_data;
   logic        req_stall;
   logic [6:0]  dcache_rd_idx;
   logic [21:0] dcache_rd_tag;
   logic        cachemem_valid;
   logic [63:0] cachemem_data;
   logic        dcache_wr_en0;
   logic [6:0]  dcache_wr_idx0;
   logic [21:0] dcache_wr_tag0;
   logic [63:0] dcache_wr_data0;
   logic        dcache_wr_en1;
   logic [6:0]  dcache_wr_idx1;
   logic [21:0] dcache_wr_tag1;
   logic [63:0] dcache_wr_data1;
   logic        cdb_load_en;
   logic [6:0]  cdb_pr;
   logic [4:0]  cdb_ar;
   logic [63:0] cdb_data;
   logic        rob_halt;
   logic        halt_done;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] perf_hits;
   logic [31:0] perf_misses;
   logic [31:0] perf_stores;
   logic [31:0] perf_cdb_conflicts;
`endif

   int total = 0;
   int bad   = 0;

   dcache_mshr_ctrl_if mem_if ();

   dcache_mshr_ctrl dut (
      .clock           (clock),
      .reset           (reset),
      .lsq_rd_mem      (lsq_rd_mem),
      .lsq_addr        (lsq_addr),
      .lsq_pr          (lsq_pr),
      .lsq_ar          (lsq_ar),
      .lsq_load_ack    (lsq_load_ack),
      .rob_wr_mem      (rob_wr_mem),
      .rob_st_addr     (rob_st_addr),
      .rob_st_data     (rob_st_data),
      .req_stall       (req_stall),
      .dcache_rd_idx   (dcache_rd_idx),
      .dcache_rd_tag   (dcache_rd_tag),
      .cachemem_valid  (cachemem_valid),
      .cachemem_data   (cachemem_data),
      .mem             (mem_if.master),
      .dcache_wr_en0   (dcache_wr_en0),
      .dcache_wr_idx0  (dcache_wr_idx0),
      .dcache_wr_tag0  (dcache_wr_tag0),
      .dcache_wr_data0 (dcache_wr_data0),
      .dcache_wr_en1   (dcache_wr_en1),
      .dcache_wr_idx1  (dcache_wr_idx1),
      .dcache_wr_tag1  (dcache_wr_tag1),
      .dcache_wr_data1 (dcache_wr_data1),
      .cdb_load_en     (cdb_load_en),
      .cdb_pr          (cdb_pr),
      .cdb_ar          (cdb_ar),
      .cdb_data        (cdb_data),
      .rob_halt        (rob_halt),
      .halt_done       (halt_done)
`ifdef DCACHE_PERF_CNT_EN
      ,
      .perf_hits          (perf_hits),
      .perf_misses        (perf_misses),
      .perf_stores        (perf_stores),
      .perf_cdb_conflicts (perf_cdb_conflicts)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   // Inputs change 2 time units after the rising edge; checks land mid-cycle.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic idle();
      lsq_rd_mem = 0; lsq_addr = '0; lsq_pr = '0; lsq_ar = '0;
      rob_wr_mem = 0; rob_st_addr = '0; rob_st_data = '0;
      cachemem_valid = 0; cachemem_data = '0; rob_halt = 0;
      mem_if.Dmem2proc_response = '0; mem_if.Dmem2proc_data = '0; mem_if.Dmem2proc_tag = '0;
   endtask

   task automatic load(input logic [63:0] a, input logic [6:0] pr, input logic [4:0] ar,
                       input logic hit, input logic [63:0] d);
      lsq_rd_mem = 1; lsq_addr = a; lsq_pr = pr; lsq_ar = ar;
      cachemem_valid = hit; cachemem_data = d;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_cmd"},   64'(mem_if.proc2Dmem_command), 64'd0);
      chk({tag, "_cdb"},   64'(cdb_load_en), 64'd0);
      chk({tag, "_wr0"},   64'(dcache_wr_en0), 64'd0);
      chk({tag, "_wr1"},   64'(dcache_wr_en1), 64'd0);
      chk({tag, "_ack"},   64'(lsq_load_ack), 64'd0);
      chk({tag, "_stall"}, 64'(req_stall), 64'd0);
      chk({tag, "_hdone"}, 64'(halt_done), 64'd0);
   endtask

   initial begin
      idle();
      reset = 1;
      tick(); tick();
      reset = 0;
      #1;
      chk_quiet("rst");
      mem_if.Dmem2proc_tag = 4'd5; mem_if.Dmem2proc_data = 64'hFF;
      #1;
      chk("rst_stray_tag_cdb", 64'(cdb_load_en), 64'd0);
      chk("rst_stray_tag_wr0", 64'(dcache_wr_en0), 64'd0);
      tick(); idle();

      // Load hit, zero latency
      load(64'h100, 7'd5, 5'd3, 1'b1, 64'hAA);
      #1;
      chk("hit_cdb_en", 64'(cdb_load_en), 64'd1);
      chk("hit_pr",     64'(cdb_pr), 64'd5);
      chk("hit_ar",     64'(cdb_ar), 64'd3);
      chk("hit_data",   cdb_data, 64'hAA);
      chk("hit_ack",    64'(lsq_load_ack), 64'd1);
      chk("hit_rd_idx", 64'(dcache_rd_idx), 64'h20);
      tick(); idle();

      // Load miss 0x200 -> tag 3 -> fill 0x55
      load(64'h200, 7'd6, 5'd4, 1'b0, 64'h0);
      #1;
      chk("miss_ack",     64'(lsq_load_ack), 64'd1);
      chk("miss_no_cdb",  64'(cdb_load_en), 64'd0);
      chk("miss_cmd_lat", 64'(mem_if.proc2Dmem_command), 64'd0);
      tick(); idle();
      chk("miss_cmd",  64'(mem_if.proc2Dmem_command), 64'd1);
      chk("miss_addr", mem_if.proc2Dmem_addr, 64'h200);
      mem_if.Dmem2proc_response = 4'd3;
      tick(); idle();
      chk("miss_popped", 64'(mem_if.proc2Dmem_command), 64'd0);
      mem_if.Dmem2proc_tag = 4'd3; mem_if.Dmem2proc_data = 64'h55;
      #1;
      chk("fill_wr0",  64'(dcache_wr_en0), 64'd1);
      chk("fill_idx0", 64'(dcache_wr_idx0), 64'h40);
      chk("fill_tag0", 64'(dcache_wr_tag0), 64'h0);
      chk("fill_cdb",  64'(cdb_load_en), 64'd1);
      chk("fill_data", cdb_data, 64'h55);
      chk("fill_pr",   64'(cdb_pr), 64'd6);
      tick(); idle();

      // Store after pending load to the same line: fill must not overwrite
      load(64'h300, 7'd7, 5'd1, 1'b0, 64'h0);
      tick(); idle();
      mem_if.Dmem2proc_response = 4'd2;
      tick(); idle();
      rob_wr_mem = 1; rob_st_addr = 64'h300; rob_st_data = 64'h77;
      #1;
      chk("st_stall", 64'(req_stall), 64'd0);
      tick(); idle();
      chk("st_cmd",  64'(mem_if.proc2Dmem_command), 64'd2);
      chk("st_data", mem_if.proc2Dmem_data, 64'h77);
      load(64'h300, 7'd8, 5'd2, 1'b1, 64'hEE);
      #1;
      chk("st_haz_no_hit", 64'(cdb_load_en), 64'd0);
      idle();
      mem_if.Dmem2proc_response = 4'd1;
      #1;
      chk("st_wr1",   64'(dcache_wr_en1), 64'd1);
      chk("st_idx1",  64'(dcache_wr_idx1), 64'h60);
      chk("st_data1", dcache_wr_data1, 64'h77);
      tick(); idle();
      mem_if.Dmem2proc_tag = 4'd2; mem_if.Dmem2proc_data = 64'h11;
      #1;
      chk("stale_cdb",  64'(cdb_load_en), 64'd1);
      chk("stale_data", cdb_data, 64'h11);
      chk("stale_pr",   64'(cdb_pr), 64'd7);
      chk("stale_wr0",  64'(dcache_wr_en0), 64'd0);
      tick(); idle();

      // Fill the FIFO with 16 stores; 17th rejected
      for (int i = 0; i < 16; i++) begin
         rob_wr_mem = 1; rob_st_addr = 64'h1000 + 64'(i * 8); rob_st_data = 64'h100 + 64'(i);
         tick();
      end
      rob_st_addr = 64'h2000; rob_st_data = 64'hDEAD;
      #1;
      chk("full_stall", 64'(req_stall), 64'd1);
      mem_if.Dmem2proc_response = 4'd1;
      #1;
      chk("full_pop_stall", 64'(req_stall), 64'd1);
      chk("full_head_data", mem_if.proc2Dmem_data, 64'h100);
      tick(); idle();
      chk("full_relieved", 64'(req_stall), 64'd0);
      for (int i = 1; i < 16; i++) begin
         mem_if.Dmem2proc_response = 4'd1;
         #1;
         chk($sformatf("drain_%0d", i), mem_if.proc2Dmem_data, 64'h100 + 64'(i));
         tick(); idle();
      end
      chk("drain_empty", 64'(mem_if.proc2Dmem_command), 64'd0);

      // Fill/hit collision on the CDB
      load(64'h400, 7'd9, 5'd6, 1'b0, 64'h0);
      tick(); idle();
      mem_if.Dmem2proc_response = 4'd4;
      tick(); idle();
      mem_if.Dmem2proc_tag = 4'd4; mem_if.Dmem2proc_data = 64'h99;
      load(64'h500, 7'd10, 5'd7, 1'b1, 64'hBB);
      #1;
      chk("coll_data", cdb_data, 64'h99);
      chk("coll_pr",   64'(cdb_pr), 64'd9);
      chk("coll_ack",  64'(lsq_load_ack), 64'd0);
      tick();
      mem_if.Dmem2proc_tag = 4'd0;
      #1;
      chk("retry_data", cdb_data, 64'hBB);
      chk("retry_pr",   64'(cdb_pr), 64'd10);
      chk("retry_ack",  64'(lsq_load_ack), 64'd1);
      tick(); idle();

      // Halt with two outstanding loads
      load(64'h600, 7'd11, 5'd8, 1'b0, 64'h0);
      tick(); idle();
      load(64'h680, 7'd12, 5'd9, 1'b0, 64'h0);
      mem_if.Dmem2proc_response = 4'd5;
      #1;
      chk("halt_b_ack", 64'(lsq_load_ack), 64'd1);
      tick(); idle();
      chk("halt_b_head", mem_if.proc2Dmem_addr, 64'h680);
      mem_if.Dmem2proc_response = 4'd6;
      rob_halt = 1;
      tick(); idle();
      chk("halt_done0", 64'(halt_done), 64'd0);
      chk("halt_stall", 64'(req_stall), 64'd1);
      load(64'h800, 7'd1, 5'd1, 1'b1, 64'h1);
      #1;
      chk("halt_no_ack", 64'(lsq_load_ack), 64'd0);
      chk("halt_no_hit", 64'(cdb_load_en), 64'd0);
      idle();
      mem_if.Dmem2proc_tag = 4'd5; mem_if.Dmem2proc_data = 64'hA5;
      #1;
      chk("halt_fill5_pr", 64'(cdb_pr), 64'd11);
      chk("halt_done1",    64'(halt_done), 64'd0);
      tick(); idle();
      mem_if.Dmem2proc_tag = 4'd6; mem_if.Dmem2proc_data = 64'hA6;
      #1;
      chk("halt_fill6_pr", 64'(cdb_pr), 64'd12);
      chk("halt_done2",    64'(halt_done), 64'd0);
      tick(); idle();
      chk("halt_done3", 64'(halt_done), 64'd1);

      // Reset mid-drain
      reset = 1;
      tick();
      reset = 0;
      load(64'h700, 7'd13, 5'd10, 1'b0, 64'h0);
      tick(); idle();
      rob_halt = 1;
      tick(); idle();
      chk("mid_cmd", 64'(mem_if.proc2Dmem_command), 64'd1);
      reset = 1;
      tick();
      reset = 0;
      #1;
      chk_quiet("mid_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/dcache_mshr_ctrl.md
Name: dcache_mshr_ctrl

Overview:
- Parametrised, non-blocking data-cache miss controller between the LSQ/ROB and the 4-bit-tagged data-memory bus.
- Load hits broadcast to the CDB in the same cycle. Load misses and all stores (write-through) queue in an in-order command FIFO and issue to memory. Load responses are matched by memory tag, written into the cache and broadcast to the CDB.
- Adds over the previous generation: backpressure, store-to-pending-load hazard handling, stale-fill suppression, CDB collision handling, and a true halt drain.

Parameters:
Q_DEPTH, 16, command FIFO entries (power of 2, ≥2)
MEM_TAGS, 15, usable memory tags 1..MEM_TAGS (tag 0 = no response)
IDX_BITS, 7, cache index width
TAG_BITS, 22, cache tag width; IDX_BITS+TAG_BITS = 29 = addr[31:3]
PR_BITS, 7, physical register width
AR_BITS, 5, architectural register width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
lsq_rd_mem  in  1  load request valid
lsq_addr  in  64  load address
lsq_pr  in  PR_BITS  load destination PR
lsq_ar  in  AR_BITS  load destination AR
lsq_load_ack  out  1  load accepted this cycle (hit broadcast or miss enqueued)
rob_wr_mem  in  1  store request valid
rob_st_addr  in  64  store address
rob_st_data  in  64  store data
req_stall  out  1  FIFO full or halted; store not accepted
dcache_rd_idx  out  IDX_BITS  lookup index = lsq_addr[IDX_BITS+2:3]
dcache_rd_tag  out  TAG_BITS  lookup tag = lsq_addr[31:IDX_BITS+3]
cachemem_valid  in  1  lookup hit
cachemem_data  in  64  lookup data
proc2Dmem_command  out  2  BUS_NONE=0 / BUS_LOAD=1 / BUS_STORE=2
proc2Dmem_addr  out  64  head address
proc2Dmem_data  out  64  head store data
Dmem2proc_response  in  4  nonzero = head accepted under this tag
Dmem2proc_data  in  64  returned data
Dmem2proc_tag  in  4  nonzero = data for this tag
dcache_wr_en0  out  1  fill write
dcache_wr_idx0  out  IDX_BITS  fill index
dcache_wr_tag0  out  TAG_BITS  fill tag
dcache_wr_data0  out  64  fill data
dcache_wr_en1  out  1  store write
dcache_wr_idx1  out  IDX_BITS  store index
dcache_wr_tag1  out  TAG_BITS  store tag
dcache_wr_data1  out  64  store data
cdb_load_en  out  1  load result valid
cdb_pr  out  PR_BITS  result PR
cdb_ar  out  AR_BITS  result AR
cdb_data  out  64  result data
rob_halt  in  1  halt request (sticky once seen)
halt_done  out  1  drained after halt

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, port reset.
- Reset clears FIFO (head=tail=count=0), tag table (occupied=0, nowrite=0) and halted.
- After reset, all outputs read 0: command=BUS_NONE, cdb_load_en=0, wr_en0/1=0, lsq_load_ack=0, req_stall=0, halt_done=0.
- Memory responses or tags arriving after reset are ignored because no table entry is occupied.
- Outputs are combinational from state and inputs. All state updates at posedge clock.
- FIFO entry fields: {cmd, addr, data, pr, ar}. Count has range 0..Q_DEPTH. Pointers wrap modulo Q_DEPTH.
- At most one enqueue per cycle.
- Store: accepted when rob_wr_mem=1 and req_stall=0. Enqueued as BUS_STORE. Has priority over a load miss in the same cycle.
- Load hit: cachemem_valid=1, no FIFO entry is a pending store whose addr[31:3] matches lsq_addr[31:3], and no fill is returning this cycle.
  - Result: cdb_load_en=1 with cachemem_data, lsq_load_ack=1, zero latency.
- Load miss: not a hit by the rule above, FIFO not full, no store enqueued this cycle, not halted.
  - Enqueued as BUS_LOAD, lsq_load_ack=1.
  - Otherwise lsq_load_ack=0 and the LSQ holds and retries.
- Issue: when count>0, the head drives proc2Dmem_*. The head is first presented one cycle after enqueue at the earliest.
  - Dmem2proc_response=0: hold the head.
  - Dmem2proc_response nonzero: pop the head.
  - Popped load: allocates table[response] = {idx, tag, pr, ar, nowrite=0}.
  - Popped store: drives dcache_wr_en1 that cycle, and sets nowrite on every occupied entry with equal idx/tag (suppresses the stale fill).
  - Response tag already occupied: simulation $error; entry overwritten.
- Fill: Dmem2proc_tag nonzero and the entry is occupied.
  - Drives cdb_load_en with Dmem2proc_data.
  - Drives dcache_wr_en0 unless nowrite is set.
  - Frees the entry.
  - Fill and hit in the same cycle: fill wins the CDB; the hit gets lsq_load_ack=0.
  - Fill and store write to the same idx in the same cycle: port1 data wins and wr_en0 is suppressed.
  - A tag freed and re-allocated in the same cycle is legal.
- Simultaneous enqueue and pop: count is unchanged. FIFO full plus pop: no enqueue until the next cycle; req_stall is not relieved combinationally.
- Halt: rob_halt sets halted. Once halted, req_stall=1 and lsq_load_ack=0, but the FIFO and outstanding entries drain. halt_done = halted & count==0 & occupied==0. Cleared only by reset.

Optional Feature:
- Macro DCACHE_PERF_CNT_EN.
- Defined: adds 32-bit saturating output counters perf_hits, perf_misses, perf_stores and perf_cdb_conflicts (a hit denied by a fill). All reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header: BUS_NONE/BUS_LOAD/BUS_STORE encodings, the FIFO entry field layout, and the default IDX/TAG widths.
- One sub-module, dcache_cmd_fifo: parametrised FIFO with count, full/empty, and a per-entry store-address match vector.
- The tag table and control logic stay in the top module.

Test Plan:
- Load hit: lsq_rd_mem=1, addr 0x100, cachemem_valid=1, data 0xAA, pr 5 → same cycle cdb_load_en=1, cdb_pr=5, cdb_data=0xAA, lsq_load_ack=1.
- Load miss: addr 0x200, next cycle BUS_LOAD to 0x200; response=3, then tag=3 with data 0x55 → wr_en0=1 at idx 0x40 and cdb_data=0x55.
- Store after pending load: load 0x300 issued with tag 2, then store 0x300 data 0x77 issued; tag 2 returns 0x11 → CDB gets 0x11, wr_en0=0, earlier wr_en1 wrote 0x77.
- Full FIFO: 16 stores with response=0 → req_stall=1 and the 17th store is ignored; one response → stall drops the next cycle.
- Fill/hit collision: tag 4 return coincides with a hit load → CDB carries the fill; the hit gets lsq_load_ack=0 and is served on retry the next cycle.
- Halt: rob_halt with 2 loads outstanding → halt_done stays 0 until both tags return, then 1; reset mid-drain → all outputs 0.
